// File: rtl/ws2811_pixel_receiver.sv
// ws2811_pixel_receiver: receive side of one WS2811 pixel.
// Decodes the NRZ pulse-width stream, keeps the first 24-bit word of each
// frame, forwards every later bit on serial_out and latches the kept word
// to rgb_out when a reset gap (long low) is seen.
// Optional build macro: WS2811_PULSE_CHECK_EN adds a pulse-length checker
// and the pulse_err_count output.
//
// Handshake: rgb_strobe is a one-cycle valid pulse with no ready; rgb_out is
// stable from that cycle until the next strobe. word_ready is a level that
// rises when the 24th bit is captured and falls at the following reset gap.
module ws2811_pixel_receiver #(
    parameter int BIT_THRESHOLD = 20,
    parameter int RESET_CYCLES  = 2500
`ifdef WS2811_PULSE_CHECK_EN
    ,
    // Pulse limits only exist when the checker is built in.
    parameter int MIN_PULSE     = 5,
    parameter int MAX_PULSE     = 60
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_in,
    output logic        serial_out,
    output logic [23:0] rgb_out,
    output logic        rgb_strobe,
    output logic        word_ready,
    output logic [1:0]  db_state
`ifdef WS2811_PULSE_CHECK_EN
    ,
    output logic [7:0]  pulse_err_count
`endif
);

    localparam int CNT_W = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] THR      = CNT_W'(BIT_THRESHOLD);
`ifdef WS2811_PULSE_CHECK_EN
    localparam logic [CNT_W-1:0] MIN_LIM  = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(MAX_PULSE);
`endif

    localparam logic [1:0] ST_WAIT_GAP = 2'd0;
    localparam logic [1:0] ST_ARM      = 2'd1;
    localparam logic [1:0] ST_HIGH     = 2'd2;
    localparam logic [1:0] ST_FORWARD  = 2'd3;

    logic             sync_q;
    logic             s_in;
    logic             s_prev;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;
    logic [1:0]       state;
    logic [4:0]       bit_cnt;
    logic [23:0]      shift_q;
    logic             rise;
    logic             fall;
    logic             gap_hit;
    logic             bit_val;

    // The data line is asynchronous; two flops before any decoding, one more
    // to find edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b0;
            s_in   <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= serial_in;
            s_in   <= sync_q;
            s_prev <= s_in;
        end
    end

    // Level-time counters: each saturates and clears on the opposite level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else if (s_in) begin
            hi_cnt <= (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + 1'b1;
            lo_cnt <= '0;
        end else begin
            lo_cnt <= (lo_cnt == CNT_MAX) ? lo_cnt : lo_cnt + 1'b1;
            hi_cnt <= '0;
        end
    end

    assign rise    = s_in & ~s_prev;
    assign fall    = ~s_in & s_prev;
    // Fires in the cycle the low time reaches RESET_CYCLES; the saturated
    // counter keeps it from firing again in the same low period.
    assign gap_hit = ~s_in & (lo_cnt == GAP_LAST);
    // On a falling edge hi_cnt still holds the full high time.
    assign bit_val = (hi_cnt >= THR);

    // Frame FSM: gap sync, bit capture, forwarding and word latch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_WAIT_GAP;
            bit_cnt    <= '0;
            shift_q    <= '0;
            word_ready <= 1'b0;
            rgb_out    <= '0;
            rgb_strobe <= 1'b0;
            serial_out <= 1'b0;
`ifdef WS2811_PULSE_CHECK_EN
            pulse_err_count <= '0;
`endif
        end else begin
            rgb_strobe <= 1'b0;
            serial_out <= (state == ST_FORWARD) & s_in;
            case (state)
                ST_WAIT_GAP: begin
                    if (gap_hit) state <= ST_ARM;
                end
                ST_ARM, ST_FORWARD: begin
                    if (gap_hit) begin
                        if (word_ready) begin
                            rgb_out    <= shift_q;
                            rgb_strobe <= 1'b1;
                        end
                        bit_cnt    <= '0;
                        word_ready <= 1'b0;
                        state      <= ST_ARM;
                    end else if (rise && state == ST_ARM) begin
                        state <= ST_HIGH;
                    end
                end
                default: begin
                    if (fall) begin
`ifdef WS2811_PULSE_CHECK_EN
                        if (hi_cnt < MIN_LIM || hi_cnt > MAX_LIM) begin
                            if (pulse_err_count != 8'hFF)
                                pulse_err_count <= pulse_err_count + 1'b1;
                            bit_cnt <= '0;
                            state   <= ST_WAIT_GAP;
                        end else
`endif
                        begin
                            shift_q <= {shift_q[22:0], bit_val};
                            if (bit_cnt == 5'd23) begin
                                bit_cnt    <= 5'd24;
                                word_ready <= 1'b1;
                                state      <= ST_FORWARD;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                state   <= ST_ARM;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign db_state = state;

endmodule

// File: doc/ws2811_pixel_receiver.md
Name: ws2811_pixel_receiver

Overview:
- Receive-side model of one WS2811 pixel: the counterpart to our array controller, which drives the serial stream.
- Decodes the single-wire NRZ pulse-width stream, captures the first 24-bit word of each frame, and forwards all later bits unchanged on serial_out to the next pixel.
- Latches the captured word to rgb_out when a reset gap is detected.
- Used in chained-pixel testbenches and as an on-FPGA loopback checker behind db_serial.

Parameters:
- BIT_THRESHOLD, 20: high-pulse length in cycles at or above which a bit decodes as 1; below decodes as 0 (0.4 us at 50 MHz).
- RESET_CYCLES, 2500: low-time in cycles that counts as a frame reset gap (50 us at 50 MHz).
- MIN_PULSE, 5: shortest legal high pulse in cycles; used only by the optional feature.
- MAX_PULSE, 60: longest legal high pulse in cycles; used only by the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- serial_in  in  1  WS2811 data line, asynchronous to clock.
- serial_out  out  1  forwarded stream for the next pixel.
- rgb_out  out  24  last latched word, first-received bit at [23].
- rgb_strobe  out  1  one-cycle pulse in the cycle rgb_out updates.
- word_ready  out  1  high once 24 bits are captured in the current frame.
- db_state  out  2  current FSM state encoding, for debug.

Behaviour:
- Synchroniser: serial_in passes through a 2-FF synchroniser to give s_in; all decoding uses s_in.
- Reset values: serial_out=0, rgb_out=0, rgb_strobe=0, word_ready=0, shift register=0, bit_cnt=0, pulse/low counters=0, state=WAIT_GAP.
- Counters: one high-time counter and one low-time counter, each saturating at RESET_CYCLES, width clog2(RESET_CYCLES+1). Each clears on the opposite level.
- WAIT_GAP (db_state 0): ignore all edges until s_in has been low for RESET_CYCLES, then go to ARM. A receiver released from reset mid-frame therefore never decodes a partial frame.
- ARM (db_state 1): on an s_in rising edge go to HIGH.
- HIGH (db_state 2), on the falling edge:
  - bit = (high count >= BIT_THRESHOLD); shift the bit in MSB-first; bit_cnt++.
  - If bit_cnt reaches 24: set word_ready=1 and go to FORWARD.
  - Otherwise return to ARM.
- FORWARD (db_state 3): serial_out = s_in registered once, so forwarding latency is 3 cycles from serial_in. In every other state serial_out=0. No re-timing or pulse reshaping is applied.
- Reset gap detection (from ARM or FORWARD): when the low counter reaches RESET_CYCLES:
  - If word_ready=1: rgb_out <= shift register and rgb_strobe=1 for exactly one cycle.
  - Always: clear bit_cnt and word_ready, then go to ARM.
  - A gap with fewer than 24 bits received leaves rgb_out unchanged and produces no strobe.
- Gap detection fires once per low period: the low counter saturates and does not re-trigger until s_in goes high.
- A high level held past RESET_CYCLES in HIGH: the counter saturates; the falling edge still decodes a 1.
- Asynchronous reset mid-frame: all state clears immediately and the block returns to WAIT_GAP.

Optional Feature:
- Macro: WS2811_PULSE_CHECK_EN.
- When defined:
  - Adds output pulse_err_count (8 bits, saturating at 255, reset 0).
  - A falling edge in HIGH with high count < MIN_PULSE or > MAX_PULSE increments pulse_err_count, does not shift, and sends the FSM to WAIT_GAP, discarding the partial word.
  - In FORWARD, pulses are not checked.
- When undefined: no extra port; all pulses decode purely on BIT_THRESHOLD.

Test Plan:
- Power-up sync: release reset with serial_in high, send 10 bits, then a 2500-cycle low -> no rgb_strobe, rgb_out=0, state ends in ARM.
- Single word: 2500-cycle gap, 24 bits of 0xA5C33C (1 = 30-cycle high, 0 = 12-cycle high, 62-cycle period), 2500-cycle low -> rgb_out=0xA5C33C and rgb_strobe high exactly one cycle.
- Chain forwarding: after a gap, 48 bits (0x123456, then 0xFEDCBA) and a gap -> rgb_out=0x123456; serial_out reproduces the second word's waveform exactly, delayed 3 cycles; serial_out stays 0 during the first 24 bits.
- Short frame: gap, 16 bits, gap -> rgb_out holds its previous value, no strobe, next full frame decodes correctly.
- Threshold edge: high pulses of 19 and 20 cycles -> decode as 0 and 1 respectively.
- With WS2811_PULSE_CHECK_EN: a 3-cycle glitch pulse in bit 5 -> pulse_err_count=1, state WAIT_GAP, no strobe at the following gap; next clean frame latches correctly.
